// File: rtl/banco_registros_pkg.sv
// Shared definitions for the register bank: default geometry, the R0
// address, write-counter width/saturation and the register-address type.
package banco_registros_pkg;

  localparam int unsigned ANCHO_DEF = 8;
  localparam int unsigned NREG_DEF  = 8;
  localparam int unsigned DIR_W_DEF = 3;

  // Address of the register that may be hardwired to zero
  localparam int unsigned DIR_R0 = 0;

  // Write counter: width and saturation value
  localparam int unsigned             CUENTA_W   = 8;
  localparam logic [CUENTA_W-1:0]     CUENTA_MAX = 8'd255;

  // Register address, shared with the write-data selector and control unit
  typedef logic [DIR_W_DEF-1:0] dir_reg_t;

endpackage

// File: rtl/banco_puerto_lectura.sv
// One combinational read port: data mux, valid lookup, R0 forced to zero.
// BANCO_BYPASS_EN: when defined, a write in flight to the selected address
// is forwarded to the output in the same cycle.
module banco_puerto_lectura
  import banco_registros_pkg::*;
#(
  parameter int unsigned ANCHO   = ANCHO_DEF,
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned DIR_W   = DIR_W_DEF,
  parameter int unsigned R0_CERO = 1
) (
  input  logic [NREG-1:0][ANCHO-1:0] datos,
  input  logic [NREG-1:0]            validos,
  input  logic [DIR_W-1:0]           sel,
  input  logic                       we,
  input  logic                       rst,
  input  logic [DIR_W-1:0]           dir_esc,
  input  logic [ANCHO-1:0]           dato_esc,
  output logic [ANCHO-1:0]           dato,
  output logic                       valido
);

  logic sel_r0;
  assign sel_r0 = (R0_CERO != 0) && (sel == DIR_W'(DIR_R0));

`ifdef BANCO_BYPASS_EN
  logic dir_esc_r0;
  assign dir_esc_r0 = (R0_CERO != 0) && (dir_esc == DIR_W'(DIR_R0));
`else
  logic unused_bypass;
  assign unused_bypass = ^{we, rst, dir_esc, dato_esc};
`endif

  // Select stored value and valid bit, then apply R0 and forwarding rules
  always_comb begin
    dato   = datos[sel];
    valido = validos[sel];
    if (sel_r0) begin
      dato = '0;
    end
`ifdef BANCO_BYPASS_EN
    if (we && !rst && (sel == dir_esc) && !dir_esc_r0) begin
      dato   = dato_esc;
      valido = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/banco_registros.sv
// General-purpose register bank: NREG x ANCHO storage, two combinational
// read ports (X, Y), per-register written-since-reset bits and a saturating
// count of accepted writes.
// BANCO_BYPASS_EN: when defined, enables same-cycle write-to-read forwarding.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int unsigned ANCHO   = ANCHO_DEF,
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned DIR_W   = DIR_W_DEF,
  parameter int unsigned R0_CERO = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [DIR_W-1:0]    DirEsc,
  input  logic [ANCHO-1:0]    Dato_Registro,
  input  logic [DIR_W-1:0]    SelX,
  input  logic [DIR_W-1:0]    SelY,
  output logic [ANCHO-1:0]    RX,
  output logic [ANCHO-1:0]    RY,
  output logic                ValidoX,
  output logic                ValidoY,
  output logic [CUENTA_W-1:0] CuentaEsc
);

  logic [NREG-1:0][ANCHO-1:0] regs;
  logic [NREG-1:0]            validos;
  logic [CUENTA_W-1:0]        cuenta;
  logic                       esc_r0;

  // Writes to R0 are accepted for counting but never stored
  assign esc_r0 = (R0_CERO != 0) && (DirEsc == DIR_W'(DIR_R0));

  // Storage, valid bits and saturating write counter; reset wins over WE
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs    <= '0;
      validos <= '0;
      cuenta  <= '0;
    end else begin
      if (WE) begin
        if (cuenta != CUENTA_MAX) begin
          cuenta <= cuenta + CUENTA_W'(1);
        end
        if (!esc_r0) begin
          regs[DirEsc]    <= Dato_Registro;
          validos[DirEsc] <= 1'b1;
        end
      end
      if (R0_CERO != 0) begin
        validos[DIR_R0] <= 1'b1;
      end
    end
  end

  assign CuentaEsc = cuenta;

  banco_puerto_lectura #(
    .ANCHO   (ANCHO),
    .NREG    (NREG),
    .DIR_W   (DIR_W),
    .R0_CERO (R0_CERO)
  ) u_puerto_x (
    .datos    (regs),
    .validos  (validos),
    .sel      (SelX),
    .we       (WE),
    .rst      (RST),
    .dir_esc  (DirEsc),
    .dato_esc (Dato_Registro),
    .dato     (RX),
    .valido   (ValidoX)
  );

  banco_puerto_lectura #(
    .ANCHO   (ANCHO),
    .NREG    (NREG),
    .DIR_W   (DIR_W),
    .R0_CERO (R0_CERO)
  ) u_puerto_y (
    .datos    (regs),
    .validos  (validos),
    .sel      (SelY),
    .we       (WE),
    .rst      (RST),
    .dir_esc  (DirEsc),
    .dato_esc (Dato_Registro),
    .dato     (RY),
    .valido   (ValidoY)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: a behavioural model predicts the
// read outputs for each cycle, predictions are queued when the stimulus is
// driven and popped/compared when outputs are sampled on the falling edge.
module tb_banco_registros;
  import banco_registros_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, WE;
  dir_reg_t   DirEsc, SelX, SelY;
  logic [7:0] Dato_Registro, RX, RY, CuentaEsc;
  logic       ValidoX, ValidoY;

  banco_registros #(
    .ANCHO   (8),
    .NREG    (8),
    .DIR_W   (3),
    .R0_CERO (1)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .WE            (WE),
    .DirEsc        (DirEsc),
    .Dato_Registro (Dato_Registro),
    .SelX          (SelX),
    .SelY          (SelY),
    .RX            (RX),
    .RY            (RY),
    .ValidoX       (ValidoX),
    .ValidoY       (ValidoY),
    .CuentaEsc     (CuentaEsc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } esperado_t;

  esperado_t cola[$];
  int unsigned vectores    = 0;
  int unsigned discrepancias = 0;

  // Reference model state
  logic [7:0] m_regs  [8];
  logic       m_valid [8];
  int unsigned m_cnt;

  task automatic comprobar(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    vectores++;
    if (obs !== esp) begin
      discrepancias++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, esp, $time);
    end
  endtask

  // Predicted {valid, data} for a read port
  function automatic logic [8:0] leer(input dir_reg_t sel);
    logic [7:0] d;
    logic       v;
    d = (sel == 3'd0) ? 8'h00 : m_regs[sel];
    v = m_valid[sel];
`ifdef BANCO_BYPASS_EN
    if (WE && !RST && sel == DirEsc && DirEsc != 3'd0) begin
      d = Dato_Registro;
      v = 1'b1;
    end
`endif
    return {v, d};
  endfunction

  task automatic modelo_flanco();
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i]  = 8'h00;
        m_valid[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      if (WE) begin
        if (m_cnt < 255) m_cnt++;
        if (DirEsc != 3'd0) begin
          m_regs[DirEsc]  = Dato_Registro;
          m_valid[DirEsc] = 1'b1;
        end
      end
      m_valid[0] = 1'b1;
    end
  endtask

  task automatic sacar(input string tag, input logic [7:0] obs);
    esperado_t e;
    if (cola.size() == 0) begin
      vectores++;
      discrepancias++;
      $display("FAIL %s: got %02h expected <empty scoreboard>", tag, obs);
    end else begin
      e = cola.pop_front();
      comprobar(e.tag, obs, e.val);
    end
  endtask

  // One clock cycle: drive, predict, sample on negedge, advance model on posedge
  task automatic ciclo(input logic rst, input logic we, input dir_reg_t dir,
                       input logic [7:0] dato, input dir_reg_t sx, input dir_reg_t sy,
                       input bit chk);
    logic [8:0] px, py;
    RST = rst; WE = we; DirEsc = dir; Dato_Registro = dato; SelX = sx; SelY = sy;
    if (chk) begin
      px = leer(sx);
      py = leer(sy);
      cola.push_back('{"RX", px[7:0]});
      cola.push_back('{"RY", py[7:0]});
      cola.push_back('{"ValidoX", {7'd0, px[8]}});
      cola.push_back('{"ValidoY", {7'd0, py[8]}});
      cola.push_back('{"CuentaEsc", 8'(m_cnt)});
    end
    @(negedge CLK);
    if (chk) begin
      sacar("RX", RX);
      sacar("RY", RY);
      sacar("ValidoX", {7'd0, ValidoX});
      sacar("ValidoY", {7'd0, ValidoY});
      sacar("CuentaEsc", CuentaEsc);
    end
    @(posedge CLK);
    modelo_flanco();
    #1;
  endtask

  initial begin
    RST = 1'b1; WE = 1'b0; DirEsc = '0; Dato_Registro = '0; SelX = '0; SelY = '0;
    m_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_valid[i] = 1'b0;
    end
    @(posedge CLK);
    #1;

    // Reset state
    ciclo(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd5, 1'b1);
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd5, 1'b1);

    // Basic write and one-cycle latency
    ciclo(1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd5, 1'b1);
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b1);

    // Write to R0: counted, not stored, valid reads 1
    ciclo(1'b0, 1'b1, 3'd0, 8'hFF, 3'd3, 3'd0, 1'b1);
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);

    // Write coinciding with reset is lost
    ciclo(1'b0, 1'b1, 3'd2, 8'h77, 3'd2, 3'd3, 1'b1);
    ciclo(1'b1, 1'b1, 3'd2, 8'h11, 3'd2, 3'd3, 1'b1);
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b1);

    // Same-cycle read of a write in flight (forwarded only with bypass)
    ciclo(1'b0, 1'b1, 3'd4, 8'h3C, 3'd4, 3'd4, 1'b1);
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 1'b1);

    // Counter saturation: 260 writes to register 7
    for (int i = 0; i < 260; i++) begin
      ciclo(1'b0, 1'b1, 3'd7, 8'(i), 3'd7, 3'd4, 1'b1);
    end
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd4, 1'b1);
    ciclo(1'b0, 1'b1, 3'd5, 8'h5A, 3'd7, 3'd5, 1'b1);
    ciclo(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 1'b1);

    // Mixed random traffic with occasional reset
    for (int i = 0; i < 60; i++) begin
      ciclo(($urandom_range(15) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(1)),
            3'($urandom_range(7)), 8'($urandom_range(255)),
            3'($urandom_range(7)), 3'($urandom_range(7)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectores, discrepancias);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/banco_registros.md
Name: banco_registros

Overview:
- General-purpose register bank for the 8-bit datapath, directly downstream of the register-write data selector.
- Captures the selected write datum (Dato_Registro) into one of NREG registers on a clock edge.
- Exposes two read ports, RX and RY; RY feeds back into the selector and the ALU.
- Tracks per-register "written since reset" validity and counts completed writes for debug/verification.

Parameters:
- ANCHO, 8, data width of each register and of all data ports.
- NREG, 8, number of registers; must be a power of two, minimum 2.
- DIR_W, 3, address width; must equal log2(NREG).
- R0_CERO, 1, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset, sampled on rising edge of CLK.
- WE  input  1  write enable for the current cycle.
- DirEsc  input  DIR_W  write address.
- Dato_Registro  input  ANCHO  write data from the selector.
- SelX  input  DIR_W  read address, port X.
- SelY  input  DIR_W  read address, port Y.
- RX  output  ANCHO  contents of register SelX.
- RY  output  ANCHO  contents of register SelY.
- ValidoX  output  1  register SelX has been written since reset.
- ValidoY  output  1  register SelY has been written since reset.
- CuentaEsc  output  8  number of accepted writes since reset; saturates at 255.

Behaviour:
- Reset (RST=1 at an edge):
  - all registers are cleared to 0, all valid bits to 0, and CuentaEsc to 0.
  - RST has priority over a simultaneous WE; that write is lost.
- Reset mid-operation: any write presented in the reset cycle is discarded; normal operation resumes on the first edge with RST=0.
- Write:
  - On a rising edge with RST=0 and WE=1, register DirEsc takes Dato_Registro and its valid bit is set to 1.
  - Latency is one cycle: the new value is visible on RX/RY in the cycle after the edge.
- R0_CERO=1 and DirEsc=0:
  - the write is "accepted" (it counts in CuentaEsc) but the storage is unchanged.
  - valid bit 0 is held at 1 permanently after reset release, so ValidoX/ValidoY read 1 for address 0.
- Read: RX/RY and ValidoX/ValidoY are combinational functions of SelX/SelY and the current state, with no read latency. Both ports may address the same register.
- CuentaEsc:
  - increments by 1 on every edge with RST=0 and WE=1.
  - holds at 255 when saturated; it never wraps.
- WE=0: no state changes and the count is held.
- Out-of-range addresses cannot occur because NREG=2^DIR_W.
- State machine: there are no multi-cycle states. The block is a register array plus a saturating counter; each cycle is independent.

Optional Feature:
- Macro: BANCO_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If WE=1, RST=0 and SelX==DirEsc (not address 0 when R0_CERO=1), RX shows Dato_Registro and ValidoX=1 in the same cycle.
  - The same rule applies to RY/ValidoY with SelY.
- Undefined: reads always return the stored value; a write is visible only from the next cycle.

Decomposition:
- Shared package: ANCHO/NREG/DIR_W defaults, the R0 address constant, and the CuentaEsc width and saturation constant (255).
- Shared package: register-address typedef, reused by the selector and the control unit.
- One natural sub-module: banco_puerto_lectura, a read mux with valid lookup and optional bypass, instantiated twice (X and Y).

Test Plan:
- Reset, then SelX=3, SelY=5 -> RX=0, RY=0, ValidoX=0, ValidoY=0, CuentaEsc=0.
- WE=1, DirEsc=3, Dato_Registro=8'hA5, one edge; then WE=0, SelX=3 -> RX=8'hA5, ValidoX=1, CuentaEsc=1. With the macro undefined, RX shows 0 during the write cycle itself.
- R0_CERO=1: write 8'hFF to address 0, read SelY=0 -> RY=0, ValidoY=1, CuentaEsc increments by 1.
- Write 8'h11 to register 2 while asserting RST=1 on the same edge -> register 2 reads 0, CuentaEsc=0.
- 260 consecutive writes (register 7, data = cycle index) -> CuentaEsc stops at 255; RX with SelX=7 shows the last data written, 8'h03 (260 mod 256 - 1).
- BANCO_BYPASS_EN defined: WE=1, DirEsc=4, Dato_Registro=8'h3C, SelX=SelY=4 in the same cycle -> RX=RY=8'h3C immediately; the stored value still reads 8'h3C on the next cycle.
